// File: rtl/vga_fb_write_arbiter.sv
// Write-port arbiter for the VGA frame buffer: two round-robin clients plus a full-screen fill engine.
// Optional macro VGA_FB_VBLANK_WRITE_EN restricts all writes to vertical blanking.
module vga_fb_write_arbiter #(
  parameter int HD        = 1280,
  parameter int VD        = 1024,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 c0_valid_i,
  output logic                 c0_ready_o,
  input  logic [1:0]           c0_color_i,
  input  logic [ADDR_BITS-1:0] c0_x_i,
  input  logic [ADDR_BITS-1:0] c0_y_i,
  input  logic                 c1_valid_i,
  output logic                 c1_ready_o,
  input  logic [1:0]           c1_color_i,
  input  logic [ADDR_BITS-1:0] c1_x_i,
  input  logic [ADDR_BITS-1:0] c1_y_i,
  input  logic                 fill_start_i,
  input  logic [1:0]           fill_color_i,
  input  logic                 vblank_i,
  output logic                 busy_o,
  output logic                 fill_done_o,
  output logic                 oob_o,
  output logic                 we_o,
  output logic [1:0]           color_o,
  output logic [ADDR_BITS-1:0] addr_x_o,
  output logic [ADDR_BITS-1:0] addr_y_o
);

  localparam logic [ADDR_BITS-1:0] X_MAX = ADDR_BITS'(HD - 1);
  localparam logic [ADDR_BITS-1:0] Y_MAX = ADDR_BITS'(VD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [ADDR_BITS-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic                 last_q, last_d;
  logic [1:0]           fcolor_q, fcolor_d;
  logic                 we_d, oob_d, done_d, busy_d;
  logic [1:0]           color_d;
  logic [ADDR_BITS-1:0] x_d, y_d;
  logic                 vb_ok, grant0, grant1, fill_issue;
  logic [ADDR_BITS-1:0] px, py, gx, gy;
  logic [1:0]           pcolor, gcolor;

`ifdef VGA_FB_VBLANK_WRITE_EN
  assign vb_ok = vblank_i;
`else
  logic unused_vblank;
  assign vb_ok         = 1'b1;
  assign unused_vblank = vblank_i;
`endif

  // rr_q = 0 prefers client 0 when both request; a fill start blocks both grants
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !fill_start_i && vb_ok) begin
      grant0 = c0_valid_i && (!c1_valid_i || !rr_q);
      grant1 = c1_valid_i && (!c0_valid_i ||  rr_q);
    end
  end

  assign c0_ready_o = grant0;
  assign c1_ready_o = grant1;
  assign gx         = grant1 ? c1_x_i     : c0_x_i;
  assign gy         = grant1 ? c1_y_i     : c0_y_i;
  assign gcolor     = grant1 ? c1_color_i : c0_color_i;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    last_d     = last_q;
    fcolor_d   = fcolor_q;
    we_d       = 1'b0;
    oob_d      = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_o;
    color_d    = color_o;
    x_d        = addr_x_o;
    y_d        = addr_y_o;
    fill_issue = 1'b0;
    px         = cnt_x_q;
    py         = cnt_y_q;
    pcolor     = fcolor_q;
    case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          state_d    = FILL;
          busy_d     = 1'b1;
          fcolor_d   = fill_color_i;
          last_d     = 1'b0;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
          px         = '0;
          py         = '0;
          pcolor     = fill_color_i;
          fill_issue = vb_ok;
        end else if (grant0 || grant1) begin
          rr_d = grant0;
          if (gx > X_MAX || gy > Y_MAX) begin
            oob_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            color_d = gcolor;
            x_d     = gx;
            y_d     = gy;
          end
        end
      end
      FILL: begin
        if (last_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          fill_issue = vb_ok;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // cnt holds the next pixel to issue; last marks that (X_MAX, Y_MAX) has gone out
    if (fill_issue) begin
      we_d    = 1'b1;
      color_d = pcolor;
      x_d     = px;
      y_d     = py;
      if (px == X_MAX) begin
        cnt_x_d = '0;
        if (py == Y_MAX) last_d = 1'b1;
        else             cnt_y_d = py + 1'b1;
      end else begin
        cnt_x_d = px + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_q        <= 1'b0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      last_q      <= 1'b0;
      fcolor_q    <= '0;
      we_o        <= 1'b0;
      oob_o       <= 1'b0;
      fill_done_o <= 1'b0;
      busy_o      <= 1'b0;
      color_o     <= '0;
      addr_x_o    <= '0;
      addr_y_o    <= '0;
    end else begin
      rr_q        <= rr_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      last_q      <= last_d;
      fcolor_q    <= fcolor_d;
      we_o        <= we_d;
      oob_o       <= oob_d;
      fill_done_o <= done_d;
      busy_o      <= busy_d;
      color_o     <= color_d;
      addr_x_o    <= x_d;
      addr_y_o    <= y_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Self-checking bench for vga_fb_write_arbiter on a 4x2 display: client table, fill, reset mid-fill,
// and (with VGA_FB_VBLANK_WRITE_EN) a vblank-gated fill.
module tb_vga_fb_write_arbiter;

  localparam int HD = 4;
  localparam int VD = 2;
  localparam int AB = 11;
`ifdef VGA_FB_VBLANK_WRITE_EN
  localparam logic VB_IDLE = 1'b1;
`else
  localparam logic VB_IDLE = 1'b0;
`endif

  logic          clk, arst;
  logic          c0_valid, c0_ready, c1_valid, c1_ready;
  logic [1:0]    c0_color, c1_color, fill_color, color;
  logic [AB-1:0] c0_x, c0_y, c1_x, c1_y, addr_x, addr_y;
  logic          fill_start, vblank, busy, fill_done, oob, we;

  vga_fb_write_arbiter #(.HD(HD), .VD(VD), .ADDR_BITS(AB)) dut (
    .clk(clk), .arst(arst),
    .c0_valid_i(c0_valid), .c0_ready_o(c0_ready), .c0_color_i(c0_color), .c0_x_i(c0_x), .c0_y_i(c0_y),
    .c1_valid_i(c1_valid), .c1_ready_o(c1_ready), .c1_color_i(c1_color), .c1_x_i(c1_x), .c1_y_i(c1_y),
    .fill_start_i(fill_start), .fill_color_i(fill_color), .vblank_i(vblank),
    .busy_o(busy), .fill_done_o(fill_done), .oob_o(oob), .we_o(we),
    .color_o(color), .addr_x_o(addr_x), .addr_y_o(addr_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v0, v1;
    logic [1:0]    c0;
    logic [AB-1:0] x0, y0;
    logic [1:0]    c1;
    logic [AB-1:0] x1, y1;
    logic          r0, r1;
  } vec_t;

  typedef struct {
    logic          oob;
    logic [1:0]    color;
    logic [AB-1:0] x, y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[15];
  int   tests = 0;
  int   fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    c0_valid = v.v0; c0_color = v.c0; c0_x = v.x0; c0_y = v.y0;
    c1_valid = v.v1; c1_color = v.c1; c1_x = v.x1; c1_y = v.y1;
  endtask

  task automatic pushFill(input logic [1:0] col);
    for (int y = 0; y < VD; y++)
      for (int x = 0; x < HD; x++)
        exp_q.push_back('{1'b0, col, AB'(x), AB'(y)});
  endtask

  // Scoreboard: every visible write or oob pulse consumes the oldest expected entry
  always @(negedge clk) begin
    if (!arst && (we || oob)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: we=%0b oob=%0b x=%0d y=%0d, expected no write", we, oob, addr_x, addr_y);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_oob", 32'(oob), 32'(mon_e.oob));
        checkOutput("sb_we", 32'(we), 32'(!mon_e.oob));
        if (!mon_e.oob) begin
          checkOutput("sb_x", 32'(addr_x), 32'(mon_e.x));
          checkOutput("sb_y", 32'(addr_y), 32'(mon_e.y));
          checkOutput("sb_color", 32'(color), 32'(mon_e.color));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic isOob(input logic [AB-1:0] x, input logic [AB-1:0] y);
    return (x >= AB'(HD)) || (y >= AB'(VD));
  endfunction

  initial begin
    logic prev_we, prev_oob, g_oob;
    int   issued;
    logic exp_we, exp_done, vbk;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 11'd3, 11'd1, 2'd0, 11'd0, 11'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 11'd0, 11'd0, 2'd0, 11'd0, 11'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 11'd1, 11'd0, 2'd3, 11'd2, 11'd1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 11'd1, 11'd0, 2'd0, 11'd0, 11'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 11'd2, 11'd0, 2'd0, 11'd0, 11'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 11'd2, 11'd0, 2'd3, 11'd3, 11'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 11'd0, 11'd0, 2'd3, 11'd3, 11'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 11'd0, 11'd0, 2'd1, 11'd4, 11'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 11'd0, 11'd0, 2'd2, 11'd1, 11'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 11'd0, 11'd0, 2'd2, 11'd1, 11'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 11'd0, 11'd2, 2'd0, 11'd0, 11'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 11'd2, 11'd1, 2'd0, 11'd0, 11'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 11'd3, 11'd1, 2'd1, 11'd2, 11'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 11'd3, 11'd1, 2'd0, 11'd0, 11'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 11'd0, 11'd0, 2'd0, 11'd0, 11'd0, 1'b0, 1'b0};

    arst = 1'b1; applyStimulus(vecs[14]);
    fill_start = 1'b0; fill_color = 2'd0; vblank = VB_IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we", 32'(we), 0);
    checkOutput("rst_oob", 32'(oob), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(fill_done), 0);
    checkOutput("rst_color", 32'(color), 0);
    checkOutput("rst_x", 32'(addr_x), 0);
    checkOutput("rst_y", 32'(addr_y), 0);
    nextCycle();
    arst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready0", 32'(c0_ready), 0);
    checkOutput("idle_we", 32'(we), 0);
    nextCycle();

    // Client arbitration table
    prev_we = 1'b0; prev_oob = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_ready0", i), 32'(c0_ready), 32'(vecs[i].r0));
      checkOutput($sformatf("tbl%0d_ready1", i), 32'(c1_ready), 32'(vecs[i].r1));
      checkOutput($sformatf("tbl%0d_we", i), 32'(we), 32'(prev_we));
      checkOutput($sformatf("tbl%0d_oob", i), 32'(oob), 32'(prev_oob));
      g_oob = 1'b0;
      if (vecs[i].r0) begin
        g_oob = isOob(vecs[i].x0, vecs[i].y0);
        exp_q.push_back('{g_oob, vecs[i].c0, vecs[i].x0, vecs[i].y0});
      end else if (vecs[i].r1) begin
        g_oob = isOob(vecs[i].x1, vecs[i].y1);
        exp_q.push_back('{g_oob, vecs[i].c1, vecs[i].x1, vecs[i].y1});
      end
      prev_we  = (vecs[i].r0 || vecs[i].r1) && !g_oob;
      prev_oob = (vecs[i].r0 || vecs[i].r1) && g_oob;
      nextCycle();
    end

    // Fill with a competing client request and an ignored restart mid-fill
    c0_valid = 1'b1; c0_color = 2'd2; c0_x = 11'd1; c0_y = 11'd1;
    fill_start = 1'b1; fill_color = 2'd1;
    @(negedge clk);
    checkOutput("fill_start_ready0", 32'(c0_ready), 0);
    checkOutput("fill_start_busy", 32'(busy), 0);
    pushFill(2'd1);
    nextCycle();
    for (int k = 1; k <= 8; k++) begin
      fill_start = (k == 3);
      fill_color = 2'd2;
      @(negedge clk);
      checkOutput($sformatf("fill%0d_we", k), 32'(we), 1);
      checkOutput($sformatf("fill%0d_busy", k), 32'(busy), 1);
      checkOutput($sformatf("fill%0d_ready0", k), 32'(c0_ready), 0);
      checkOutput($sformatf("fill%0d_done", k), 32'(fill_done), 0);
      nextCycle();
    end
    fill_start = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'(fill_done), 1);
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_we", 32'(we), 0);
    checkOutput("done_ready0", 32'(c0_ready), 0);
    nextCycle();
    @(negedge clk);
    checkOutput("after_done_pulse", 32'(fill_done), 0);
    checkOutput("after_done_ready0", 32'(c0_ready), 1);
    exp_q.push_back('{1'b0, 2'd2, 11'd1, 11'd1});
    nextCycle();
    c0_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_fill_client_we", 32'(we), 1);
    nextCycle();

    // Reset in the middle of a fill
    fill_start = 1'b1; fill_color = 2'd3;
    @(negedge clk);
    pushFill(2'd3);
    nextCycle();
    fill_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("pre_rst%0d_we", k), 32'(we), 1);
      nextCycle();
    end
    arst = 1'b1;
    #1;
    checkOutput("midrst_we", 32'(we), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_x", 32'(addr_x), 0);
    checkOutput("midrst_y", 32'(addr_y), 0);
    checkOutput("midrst_color", 32'(color), 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midrst_done", 32'(fill_done), 0);
      nextCycle();
    end
    arst = 1'b0;
    fill_start = 1'b1; fill_color = 2'd2;
    @(negedge clk);
    checkOutput("refill_busy0", 32'(busy), 0);
    pushFill(2'd2);
    nextCycle();
    fill_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("refill%0d_we", k), 32'(we), 32'(k <= 8));
      checkOutput($sformatf("refill%0d_done", k), 32'(fill_done), 32'(k == 9));
      checkOutput($sformatf("refill%0d_done_early", k), 32'(fill_done && k < 9), 0);
      nextCycle();
    end

`ifdef VGA_FB_VBLANK_WRITE_EN
    // Fill gated by vblank: 3 cycles high, 2 low
    fill_start = 1'b1; fill_color = 2'd1; vblank = 1'b1;
    @(negedge clk);
    checkOutput("vb_start_we", 32'(we), 0);
    pushFill(2'd1);
    issued = 1; exp_we = 1'b1; exp_done = 1'b0;
    nextCycle();
    fill_start = 1'b0;
    for (int k = 1; k < 60; k++) begin
      vbk = ((k % 5) < 3);
      vblank = vbk;
      @(negedge clk);
      checkOutput($sformatf("vb%0d_we", k), 32'(we), 32'(exp_we));
      checkOutput($sformatf("vb%0d_done", k), 32'(fill_done), 32'(exp_done));
      checkOutput($sformatf("vb%0d_busy", k), 32'(busy), 32'(!exp_done));
      if (exp_done) break;
      if (exp_we && issued == 8) begin
        exp_done = 1'b1;
        exp_we   = 1'b0;
      end else begin
        exp_we = vbk && (issued < 8);
        if (exp_we) issued++;
      end
      nextCycle();
    end
    nextCycle();
    vblank = VB_IDLE;
`endif

    nextCycle();
    checkOutput("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
